// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter: 64-slot frame, MSB-first samples in 32-bit slots, one-bit I2S delay.
// Bit clock comes from a fractional accumulator on clk_sys; no back-pressure, inputs latched at frame start.
module i2s_audio_tx #(
  parameter int CLK_RATE    = 84_000_000,
  parameter int SAMPLE_RATE = 48_000,
  parameter int WIDTH       = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] left_chan,
  input  logic [WIDTH-1:0] right_chan,
  output logic             sample_stb,
  output logic             sclk,
  output logic             lrclk,
  output logic             sdata
);

  localparam logic [32:0] STEP = 33'(128 * SAMPLE_RATE);
  localparam logic [32:0] RATE = 33'(CLK_RATE);

  if (128 * SAMPLE_RATE > CLK_RATE) begin : g_rate_check
    $error("i2s_audio_tx: 128*SAMPLE_RATE must not exceed CLK_RATE");
  end
  if (WIDTH < 1 || WIDTH > 31) begin : g_width_check
    $error("i2s_audio_tx: WIDTH must be in 1..31");
  end

  logic [31:0]      acc_q, acc_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             stb_q, stb_d;
  logic [5:0]       bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shadow_l_q, shadow_l_d;
  logic [WIDTH-1:0] shadow_r_q, shadow_r_d;

  logic [32:0] sum;
  logic        tick;
  logic        fall;
  logic [5:0]  bitcnt_n;
  logic [4:0]  slot;
  logic [WIDTH-1:0] word;
  logic [31:0] slot_img;

  always_comb begin
    sum      = {1'b0, acc_q} + STEP;
    tick     = (sum >= RATE);
    acc_d    = tick ? 32'(sum - RATE) : sum[31:0];
    fall     = tick & sclk_q;
    bitcnt_n = bitcnt_q + 6'd1;
    slot     = bitcnt_n[4:0];
    word     = bitcnt_n[5] ? shadow_r_q : shadow_l_q;
    // Sample MSB lands at slot 1; slot 0 and everything past the LSB read as zero.
    slot_img = 32'(word) << (31 - WIDTH);

    sclk_d     = tick ? ~sclk_q : sclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    bitcnt_d   = bitcnt_q;
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    stb_d      = 1'b0;

    if (fall) begin
      bitcnt_d = bitcnt_n;
      lrclk_d  = bitcnt_n[5];
      sdata_d  = slot_img[5'd31 - slot];
      if (bitcnt_n == 6'd0) begin
        shadow_l_d = left_chan;
        shadow_r_d = right_chan;
        stb_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc_q      <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      stb_q      <= 1'b0;
      bitcnt_q   <= 6'd63;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
    end else begin
      acc_q      <= acc_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      stb_q      <= stb_d;
      bitcnt_q   <= bitcnt_d;
      shadow_l_q <= shadow_l_d;
      shadow_r_q <= shadow_r_d;
    end
  end

  assign sample_stb = stb_q;
  assign sclk       = sclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: default 84 MHz / 48 kHz instance plus a tick-every-clock instance.
module tb_i2s_audio_tx;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset_n, rst_f_n;
  logic [15:0] left_chan, right_chan;
  logic        d_stb, d_sclk, d_lr, d_sd;
  logic        f_stb, f_sclk, f_lr, f_sd;
  logic        sel;
  logic        m_stb, m_sclk, m_lr, m_sd;

  int n_vec = 0;
  int n_err = 0;

  i2s_audio_tx #(.CLK_RATE(84_000_000), .SAMPLE_RATE(48_000), .WIDTH(16)) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .left_chan(left_chan), .right_chan(right_chan),
    .sample_stb(d_stb), .sclk(d_sclk), .lrclk(d_lr), .sdata(d_sd)
  );

  i2s_audio_tx #(.CLK_RATE(12_800), .SAMPLE_RATE(100), .WIDTH(16)) u_fast (
    .clk_sys(clk_sys), .reset_n(rst_f_n), .left_chan(left_chan), .right_chan(right_chan),
    .sample_stb(f_stb), .sclk(f_sclk), .lrclk(f_lr), .sdata(f_sd)
  );

  assign m_stb  = sel ? f_stb  : d_stb;
  assign m_sclk = sel ? f_sclk : d_sclk;
  assign m_lr   = sel ? f_lr   : d_lr;
  assign m_sd   = sel ? f_sd   : d_sd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sclk"}, 64'(m_sclk), 64'd0);
    chk({tag, "_lrclk"}, 64'(m_lr), 64'd1);
    chk({tag, "_sdata"}, 64'(m_sd), 64'd0);
    chk({tag, "_stb"}, 64'(m_stb), 64'd0);
  endtask

  // Counts clocks and sclk toggles until sample_stb is seen.
  task automatic wait_stb(output int cyc, output int tog);
    logic prev;
    prev = m_sclk;
    cyc  = 0;
    tog  = 0;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (m_sclk !== prev) tog++;
      prev = m_sclk;
      if (m_stb === 1'b1) break;
      if (cyc >= 5000) begin
        chk("wait_stb_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  // Called just after a strobe; records sdata/lrclk at each sclk rise until the next strobe.
  task automatic collect(input int chg_at, input logic [15:0] chg_val,
                         output logic [63:0] bits, output logic [63:0] lrs,
                         output int clks, output int rises, output int hmin, output int hmax);
    logic prev;
    int   since;
    prev  = m_sclk;
    bits  = '0;
    lrs   = '0;
    clks  = 0;
    rises = 0;
    since = 0;
    hmin  = 1000;
    hmax  = 0;
    forever begin
      @(negedge clk_sys);
      clks++;
      since++;
      if (m_sclk !== prev) begin
        if (since < hmin) hmin = since;
        if (since > hmax) hmax = since;
        since = 0;
        if (m_sclk === 1'b1) begin
          if (rises < 64) begin
            bits[rises] = m_sd;
            lrs[rises]  = m_lr;
          end
          rises++;
          if (rises == chg_at) left_chan = chg_val;
        end
      end
      prev = m_sclk;
      if (m_stb === 1'b1) break;
      if (clks >= 5000) begin
        chk("collect_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] bits, input logic [63:0] lrs,
                             input int clks, input int rises, input int hmin, input int hmax,
                             input logic [15:0] exp_l, input logic [15:0] exp_r,
                             input int exp_clks, input int exp_min, input int exp_max);
    logic [15:0] l, r;
    for (int i = 0; i < 16; i++) begin
      l[15-i] = bits[1+i];
      r[15-i] = bits[33+i];
    end
    chk({tag, "_rises"}, 64'(rises), 64'd64);
    chk({tag, "_spacing"}, 64'(clks), 64'(exp_clks));
    chk({tag, "_lrclk"}, lrs, 64'hFFFF_FFFF_0000_0000);
    chk({tag, "_left"}, 64'(l), 64'(exp_l));
    chk({tag, "_right"}, 64'(r), 64'(exp_r));
    chk({tag, "_padzero"}, 64'({bits[63:49], bits[32:17], bits[0]}), 64'd0);
    chk({tag, "_hmin"}, 64'(hmin), 64'(exp_min));
    chk({tag, "_hmax"}, 64'(hmax), 64'(exp_max));
  endtask

  initial begin
    logic [63:0] bits, lrs;
    int cyc, tog, clks, rises, hmin, hmax, r;
    logic prev;

    sel        = 1'b0;
    reset_n    = 1'b0;
    rst_f_n    = 1'b0;
    left_chan  = 16'hA5C3;
    right_chan = 16'h8001;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk_reset_outputs("rst");
    end
    reset_n = 1'b1;

    // acc needs 14 steps per tick from 0, and 14 more for the second: strobe after clock 28.
    wait_stb(cyc, tog);
    chk("first_stb_cycles", 64'(cyc), 64'd28);
    chk("first_stb_toggles", 64'(tog), 64'd2);

    collect(-1, 16'h0, bits, lrs, clks, rises, hmin, hmax);
    check_frame("frA", bits, lrs, clks, rises, hmin, hmax, 16'hA5C3, 16'h8001, 1750, 13, 14);

    collect(5, 16'h1234, bits, lrs, clks, rises, hmin, hmax);
    check_frame("frB", bits, lrs, clks, rises, hmin, hmax, 16'hA5C3, 16'h8001, 1750, 13, 14);

    for (int f = 0; f < 8; f++) begin
      collect(-1, 16'h0, bits, lrs, clks, rises, hmin, hmax);
      check_frame($sformatf("fr%0d", f + 3), bits, lrs, clks, rises, hmin, hmax,
                  16'h1234, 16'h8001, 1750, 13, 14);
    end

    // Reset pulse right after the slot-40 rise.
    r    = 0;
    cyc  = 0;
    prev = m_sclk;
    while (r < 41 && cyc < 5000) begin
      @(negedge clk_sys);
      cyc++;
      if (m_sclk === 1'b1 && prev === 1'b0) r++;
      prev = m_sclk;
    end
    chk("slot40_reached", 64'(r), 64'd41);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk_reset_outputs("midrst");
    reset_n = 1'b1;
    wait_stb(cyc, tog);
    chk("midrst_stb_cycles", 64'(cyc), 64'd28);
    chk("midrst_stb_toggles", 64'(tog), 64'd2);
    collect(-1, 16'h0, bits, lrs, clks, rises, hmin, hmax);
    check_frame("frR", bits, lrs, clks, rises, hmin, hmax, 16'h1234, 16'h8001, 1750, 13, 14);

    // STEP equals CLK_RATE: sclk toggles every clock, 128 clocks per frame.
    sel       = 1'b1;
    left_chan = 16'hA5C3;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk_reset_outputs("fast_rst");
    rst_f_n = 1'b1;
    wait_stb(cyc, tog);
    chk("fast_stb_cycles", 64'(cyc), 64'd2);
    chk("fast_stb_toggles", 64'(tog), 64'd2);
    collect(-1, 16'h0, bits, lrs, clks, rises, hmin, hmax);
    check_frame("fast1", bits, lrs, clks, rises, hmin, hmax, 16'hA5C3, 16'h8001, 128, 1, 1);
    right_chan = 16'h7FFE;
    collect(-1, 16'h0, bits, lrs, clks, rises, hmin, hmax);
    check_frame("fast2", bits, lrs, clks, rises, hmin, hmax, 16'hA5C3, 16'h8001, 128, 1, 1);
    collect(-1, 16'h0, bits, lrs, clks, rises, hmin, hmax);
    check_frame("fast3", bits, lrs, clks, rises, hmin, hmax, 16'hA5C3, 16'h7FFE, 128, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
